dmem_responder: RTL and testbench



---
 rtl/dmem_responder.sv | 133 +++++++++++++
 tb/tb_dmem_responder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the CPU MEM stage: word storage with counter-driven latency and stall.
// Optional build macro DMEM_DEBUG_EN adds a debug read port and a clean-access counter.
module dmem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2,
  parameter int CNT_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_ren,
  input  logic                  mem_wen,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_dout,
`ifdef DMEM_DEBUG_EN
  input  logic [ADDR_WIDTH-1:0] debug_addr,
  output logic [31:0]           debug_data,
  output logic [15:0]           acc_count,
`endif
  output logic [31:0]           mem_din,
  output logic                  mem_stall,
  output logic                  mem_err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [CNT_WIDTH-1:0] WAIT_LAST = CNT_WIDTH'(WAIT_CYCLES - 1);

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [31:0]            mem_q [2**ADDR_WIDTH];

  logic                   req;
  logic                   stall_raw;
  logic                   cmpl_raw;
  logic                   cmpl;
  logic                   misaligned;
  logic                   wr_en;
  logic                   rd_en;
  logic [ADDR_WIDTH-1:0]  idx;
  logic                   unused_addr;

  assign req         = mem_ren | mem_wen;
  assign idx         = mem_addr[ADDR_WIDTH+1:2];
  assign misaligned  = |mem_addr[1:0];
  assign unused_addr = &{1'b0, mem_addr[31:ADDR_WIDTH+2]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_raw = 1'b0;
    cmpl_raw  = 1'b0;
    if (WAIT_CYCLES == 0) begin
      cmpl_raw = req;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            stall_raw = 1'b1;
            if (WAIT_CYCLES == 1) begin
              state_d = DONE;
            end else begin
              state_d = BUSY;
              cnt_d   = CNT_WIDTH'(1);
            end
          end
        end
        BUSY: begin
          // A dropped request here is a pipeline flush: abandon the access.
          if (!req) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            stall_raw = 1'b1;
            if (cnt_q == WAIT_LAST) begin
              state_d = DONE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_WIDTH'(1);
            end
          end
        end
        DONE: begin
          cmpl_raw = req;
          state_d  = IDLE;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are forced quiet while reset is asserted, so a reset mid-access drops them at once.
  assign cmpl      = cmpl_raw & rst_n;
  assign mem_stall = stall_raw & rst_n;
  assign mem_err   = cmpl & (misaligned | (mem_ren & mem_wen));
  assign wr_en     = cmpl & mem_wen & ~misaligned;
  assign rd_en     = cmpl & mem_ren & ~mem_wen & ~misaligned;
  assign mem_din   = rd_en ? mem_q[idx] : 32'h0;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[idx] <= mem_dout;
    end
  end

`ifdef DMEM_DEBUG_EN
  logic [15:0] acc_q;

  assign debug_data = mem_q[debug_addr];
  assign acc_count  = acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (cmpl && !mem_err) begin
      acc_q <= acc_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance
// checked against an array-based model of the storage and the fixed access latency.
module tb_dmem_responder;
  localparam int AW    = 10;
  localparam int W     = 2;
  localparam int DEPTH = 1 << AW;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ren, wen, stall, err;
  logic [31:0] addr, dout, din;
  logic        ren0, wen0, stall0, err0;
  logic [31:0] addr0, dout0, din0;
`ifdef DMEM_DEBUG_EN
  logic [AW-1:0] dbg_addr;
  logic [31:0]   dbg_data;
  logic [15:0]   acc;
  logic [AW-1:0] dbg_unused_addr;
  logic [31:0]   dbg_unused_data;
  logic [15:0]   acc_unused;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  int          acc_exp  = 0;
  logic [31:0] model  [DEPTH];
  bit          valid  [DEPTH];
  logic [31:0] model0 [DEPTH];
  bit          valid0 [DEPTH];

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(W), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .mem_ren(ren), .mem_wen(wen), .mem_addr(addr), .mem_dout(dout),
`ifdef DMEM_DEBUG_EN
    .debug_addr(dbg_addr), .debug_data(dbg_data), .acc_count(acc),
`endif
    .mem_din(din), .mem_stall(stall), .mem_err(err)
  );

  dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0), .CNT_WIDTH(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .mem_ren(ren0), .mem_wen(wen0), .mem_addr(addr0), .mem_dout(dout0),
`ifdef DMEM_DEBUG_EN
    .debug_addr(dbg_unused_addr), .debug_data(dbg_unused_data), .acc_count(acc_unused),
`endif
    .mem_din(din0), .mem_stall(stall0), .mem_err(err0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge ending the completion cycle,
  // with the request still driven so a following call is back-to-back.
  task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    int          i;
    bit          mis;
    logic        exp_err;
    logic [31:0] exp_din;
    i       = int'((a >> 2) % DEPTH);
    mis     = (a % 4) != 0;
    exp_err = mis || (r && w);
    exp_din = (r && !w && !mis) ? model[i] : 32'h0;
    ren = r; wen = w; addr = a; dout = d;
    for (int c = 0; c < W; c++) begin
      @(negedge clk);
      chk("stall_hi", {31'b0, stall}, 32'd1);
      chk("din_busy", din, 32'h0);
      chk("err_busy", {31'b0, err}, 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("stall_done", {31'b0, stall}, 32'd0);
    chk("err_done", {31'b0, err}, {31'b0, exp_err});
    chk("din_done", din, exp_din);
    @(posedge clk); #1;
    if (w && !mis) begin
      model[i] = d;
      valid[i] = 1'b1;
    end
    if (!exp_err) acc_exp++;
  endtask

  task automatic idle();
    ren = 1'b0; wen = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic access0(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    int          i;
    bit          mis;
    logic        exp_err;
    logic [31:0] exp_din;
    i       = int'((a >> 2) % DEPTH);
    mis     = (a % 4) != 0;
    exp_err = mis || (r && w);
    exp_din = (r && !w && !mis) ? model0[i] : 32'h0;
    ren0 = r; wen0 = w; addr0 = a; dout0 = d;
    @(negedge clk);
    chk("w0_stall", {31'b0, stall0}, 32'd0);
    chk("w0_err", {31'b0, err0}, {31'b0, exp_err});
    chk("w0_din", din0, exp_din);
    @(posedge clk); #1;
    if (w && !mis) begin
      model0[i] = d;
      valid0[i] = 1'b1;
    end
  endtask

  // Request is dropped during the first BUSY cycle.
  task automatic abort(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    ren = r; wen = w; addr = a; dout = d;
    @(negedge clk);
    chk("abort_stall0", {31'b0, stall}, 32'd1);
    @(posedge clk); #1;
    ren = 1'b0; wen = 1'b0;
    #1;
    chk("abort_stall", {31'b0, stall}, 32'd0);
    chk("abort_din", din, 32'h0);
    chk("abort_err", {31'b0, err}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_idle", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic rand_op(output logic r, output logic w, output logic [31:0] a, output logic [31:0] d,
                         input bit for_w0);
    int  idx, kind;
    bit  mis;
    bit  known;
    idx  = $urandom_range(0, 15);
    mis  = ($urandom_range(0, 4) == 0);
    a    = ($urandom & 32'hFFFF_F000) | (idx << 2) | (mis ? $urandom_range(1, 3) : 0);
    d    = $urandom;
    kind = $urandom_range(0, 9);
    known = for_w0 ? valid0[idx] : valid[idx];
    if (kind == 0) begin
      r = 1'b1; w = 1'b1;
    end else if (kind < 5 || (!mis && !known)) begin
      r = 1'b0; w = 1'b1;
    end else begin
      r = 1'b1; w = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        r, w;
    logic [31:0] a, d;
    rst_n = 1'b0;
    ren = 0; wen = 0; addr = 0; dout = 0;
    ren0 = 0; wen0 = 0; addr0 = 0; dout0 = 0;
`ifdef DMEM_DEBUG_EN
    dbg_addr = '0; dbg_unused_addr = '0;
`endif
    #2;
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_din", din, 32'h0);
    chk("rst_stall0", {31'b0, stall0}, 32'd0);
`ifdef DMEM_DEBUG_EN
    chk("rst_acc", {16'b0, acc}, 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Store then load with latency, plus back-to-back same-address store/load.
    access(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    idle();
    access(1'b1, 1'b0, 32'h0000_0010, 32'h0);
    access(1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_0001);
    access(1'b1, 1'b0, 32'h0000_0020, 32'h0);
    idle();

    // Zero-latency instance.
    access0(1'b0, 1'b1, 32'h0000_0004, 32'h1234_5678);
    access0(1'b1, 1'b0, 32'h0000_0004, 32'h0);
    ren0 = 1'b0; wen0 = 1'b0;

    // Misaligned store is dropped.
    access(1'b0, 1'b1, 32'h0000_0013, 32'hAAAA_AAAA);
    idle();
    access(1'b1, 1'b0, 32'h0000_0010, 32'h0);
    idle();

    // Aborted load, then an aborted store that must not write.
    abort(1'b1, 1'b0, 32'h0000_0010, 32'h0);
    access(1'b1, 1'b0, 32'h0000_0010, 32'h0);
    idle();
    abort(1'b0, 1'b1, 32'h0000_0010, 32'h0BAD_0BAD);
    access(1'b1, 1'b0, 32'h0000_0010, 32'h0);
    idle();

    // Address aliasing and simultaneous read+write.
    access(1'b0, 1'b1, 32'h0000_1000, 32'h0000_0055);
    idle();
    access(1'b1, 1'b0, 32'h0000_0000, 32'h0);
    idle();
    access(1'b1, 1'b1, 32'h0000_0008, 32'h0000_0077);
    idle();
    access(1'b1, 1'b0, 32'h0000_0008, 32'h0);
    idle();

    // Reset in the middle of a store.
    ren = 1'b0; wen = 1'b1; addr = 32'h0000_0010; dout = 32'h1111_1111;
    @(negedge clk);
    chk("rstmid_stall_pre", {31'b0, stall}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rstmid_stall", {31'b0, stall}, 32'd0);
    chk("rstmid_err", {31'b0, err}, 32'd0);
    ren = 1'b0; wen = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    acc_exp = 0;
`ifdef DMEM_DEBUG_EN
    chk("acc_after_rst", {16'b0, acc}, 32'd0);
`endif
    @(posedge clk); #1;
    access(1'b1, 1'b0, 32'h0000_0010, 32'h0);
    idle();
    access(1'b0, 1'b1, 32'h0000_0030, 32'h0000_3333);
    access(1'b1, 1'b0, 32'h0000_0030, 32'h0);
    idle();
`ifdef DMEM_DEBUG_EN
    chk("acc_three", {16'b0, acc}, 32'd3);
`endif

    // Randomized traffic on both instances.
    for (int k = 0; k < 80; k++) begin
      rand_op(r, w, a, d, 1'b0);
      access(r, w, a, d);
      if ($urandom_range(0, 2) == 0) idle();
    end
    idle();
    for (int k = 0; k < 40; k++) begin
      rand_op(r, w, a, d, 1'b1);
      access0(r, w, a, d);
    end
    ren0 = 1'b0; wen0 = 1'b0;
    @(posedge clk); #1;

`ifdef DMEM_DEBUG_EN
    chk("acc_final", {16'b0, acc}, acc_exp[31:0] & 32'hFFFF);
    dbg_addr = AW'(4);
    #1;
    chk("debug_data", dbg_data, model[4]);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
